// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants for the hazard scoreboard.
// The stage record and the default HI/LO latencies live here.
package cpu_pkg;

    localparam logic [2:0]  FWD_NONE     = 3'd0;
    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    typedef struct packed {
        logic       valid;
        logic [4:0] wa;
        logic [2:0] tnew;
    } stage_rec_t;

    function automatic logic [2:0] tnew_dec(input logic [2:0] t);
        return (t == 3'd0) ? 3'd0 : t - 3'd1;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO unit busy tracker: loads the op latency on issue, then counts down to idle.
module md_busy_counter
    import cpu_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic is_div_i,
    output logic busy_o
);

    localparam int unsigned CntMax = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    logic [CntW-1:0] md_cnt_q, md_cnt_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (load_i) begin
            md_cnt_d = is_div_i ? CntW'(DIV_CYC) : CntW'(MULT_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writers after D, decides stall and forwarding sources for the
// D-stage operands, and interlocks HI/LO accesses against a busy mult/div unit.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned NSTAGE   = 3,
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_rs_en,
    input  logic       rd_rt_en,
    input  logic [4:0] ra_rs,
    input  logic [4:0] ra_rt,
    input  logic [2:0] tuse_rs,
    input  logic [2:0] tuse_rt,
    input  logic       wr_en,
    input  logic [4:0] wa,
    input  logic [2:0] tnew,
    input  logic       md_start,
    input  logic       md_is_div,
    input  logic       md_use,
    input  logic       flush,
    output logic       stall,
    output logic [2:0] fwd_rs,
    output logic [2:0] fwd_rt,
    output logic       md_busy
);

    stage_rec_t stage_q [1:NSTAGE];
    stage_rec_t stage_d [1:NSTAGE];

    logic       rs_hit, rt_hit;
    logic [2:0] rs_idx, rt_idx;
    logic [2:0] rs_tnew, rt_tnew;
    logic       rs_req, rt_req;
    logic       rs_haz, rt_haz, md_haz;
    logic       md_load;

    // Scan oldest to youngest so the lowest matching stage wins.
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_idx  = FWD_NONE;
        rt_idx  = FWD_NONE;
        rs_tnew = 3'd0;
        rt_tnew = 3'd0;
        for (int k = int'(NSTAGE); k >= 1; k--) begin
            if (stage_q[k].valid && stage_q[k].wa == ra_rs) begin
                rs_hit  = 1'b1;
                rs_idx  = 3'(k);
                rs_tnew = stage_q[k].tnew;
            end
            if (stage_q[k].valid && stage_q[k].wa == ra_rt) begin
                rt_hit  = 1'b1;
                rt_idx  = 3'(k);
                rt_tnew = stage_q[k].tnew;
            end
        end
    end

    assign rs_req = rd_rs_en && (ra_rs != 5'd0) && rs_hit;
    assign rt_req = rd_rt_en && (ra_rt != 5'd0) && rt_hit;
    assign rs_haz = rs_req && (rs_tnew > tuse_rs);
    assign rt_haz = rt_req && (rt_tnew > tuse_rt);
    assign md_haz = (md_start || md_use) && md_busy;

    assign stall  = (rs_haz || rt_haz || md_haz) && !flush;
    assign fwd_rs = (rs_req && rs_tnew == 3'd0) ? rs_idx : FWD_NONE;
    assign fwd_rt = (rt_req && rt_tnew == 3'd0) ? rt_idx : FWD_NONE;

    always_comb begin
        for (int k = 1; k <= int'(NSTAGE); k++) begin
            stage_d[k] = '0;
        end
        if (!stall && !flush) begin
            stage_d[1].valid = wr_en && (wa != 5'd0);
            stage_d[1].wa    = wa;
            stage_d[1].tnew  = tnew;
        end
        for (int k = 2; k <= int'(NSTAGE); k++) begin
            stage_d[k].valid = stage_q[k-1].valid && !flush;
            stage_d[k].wa    = stage_q[k-1].wa;
            stage_d[k].tnew  = tnew_dec(stage_q[k-1].tnew);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= int'(NSTAGE); k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= int'(NSTAGE); k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // A flushed or stalled mult/div never issues, but one already running keeps counting.
    assign md_load = md_start && !stall && !flush;

    md_busy_counter #(
        .MULT_CYC(MULT_CYC),
        .DIV_CYC (DIV_CYC)
    ) u_md_busy_counter (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (md_load),
        .is_div_i(md_is_div),
        .busy_o  (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed pipeline scenarios plus random traffic, compared each cycle
// against an age-based model of in-flight writers and a HI/LO busy deadline.
module tb_hazard_scoreboard;

    localparam int unsigned NSTAGE   = 3;
    localparam int unsigned MULT_CYC = 5;
    localparam int unsigned DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_rs_en, rd_rt_en;
    logic [4:0] ra_rs, ra_rt;
    logic [2:0] tuse_rs, tuse_rt;
    logic       wr_en;
    logic [4:0] wa;
    logic [2:0] tnew;
    logic       md_start, md_is_div, md_use, flush;
    logic       stall;
    logic [2:0] fwd_rs, fwd_rt;
    logic       md_busy;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NSTAGE  (NSTAGE),
        .MULT_CYC(MULT_CYC),
        .DIV_CYC (DIV_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_rs_en (rd_rs_en),
        .rd_rt_en (rd_rt_en),
        .ra_rs    (ra_rs),
        .ra_rt    (ra_rt),
        .tuse_rs  (tuse_rs),
        .tuse_rt  (tuse_rt),
        .wr_en    (wr_en),
        .wa       (wa),
        .tnew     (tnew),
        .md_start (md_start),
        .md_is_div(md_is_div),
        .md_use   (md_use),
        .flush    (flush),
        .stall    (stall),
        .fwd_rs   (fwd_rs),
        .fwd_rt   (fwd_rt),
        .md_busy  (md_busy)
    );

    // Each issued writer remembers its destination, the cycle it entered stage 1 and its
    // latency; its stage and remaining latency follow from its age.
    typedef struct {
        int wa;
        int t0;
        int tn;
    } inflight_t;

    inflight_t  q[$];
    int         cyc;
    int         busy_end;
    int         checks;
    int         failures;
    logic       exp_stall, exp_busy;
    logic [2:0] exp_fwd_rs, exp_fwd_rt;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] want);
        checks++;
        assert (got === want)
        else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic lookup(input int ra, output int stg, output int rem);
        int s;
        stg = 0;
        rem = 0;
        foreach (q[i]) begin
            s = cyc - q[i].t0 + 1;
            if (s >= 1 && s <= int'(NSTAGE) && q[i].wa == ra && (stg == 0 || s < stg)) begin
                stg = s;
                rem = (q[i].tn > s - 1) ? q[i].tn - (s - 1) : 0;
            end
        end
    endtask

    task automatic model_eval();
        int   srs, rrs, srt, rrt;
        logic hz;
        lookup(int'(ra_rs), srs, rrs);
        lookup(int'(ra_rt), srt, rrt);
        hz         = 1'b0;
        exp_fwd_rs = 3'd0;
        exp_fwd_rt = 3'd0;
        if (rd_rs_en && ra_rs != 5'd0 && srs != 0) begin
            if (rrs > int'(tuse_rs)) hz = 1'b1;
            if (rrs == 0) exp_fwd_rs = 3'(srs);
        end
        if (rd_rt_en && ra_rt != 5'd0 && srt != 0) begin
            if (rrt > int'(tuse_rt)) hz = 1'b1;
            if (rrt == 0) exp_fwd_rt = 3'(srt);
        end
        exp_busy = (cyc < busy_end);
        if ((md_start || md_use) && exp_busy) hz = 1'b1;
        exp_stall = hz && !flush;
    endtask

    task automatic settle(input string tag);
        #1;
        model_eval();
        check({tag, ".stall"},   {2'b00, stall},   {2'b00, exp_stall});
        check({tag, ".fwd_rs"},  fwd_rs,           exp_fwd_rs);
        check({tag, ".fwd_rt"},  fwd_rt,           exp_fwd_rt);
        check({tag, ".md_busy"}, {2'b00, md_busy}, {2'b00, exp_busy});
    endtask

    task automatic tick();
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else if (!exp_stall && wr_en && wa != 5'd0) begin
            q.push_back('{int'(wa), cyc + 1, int'(tnew)});
        end
        if (md_start && !exp_stall && !flush) begin
            busy_end = cyc + 1 + (md_is_div ? int'(DIV_CYC) : int'(MULT_CYC));
        end
        while (q.size() > 0 && (cyc + 1 - q[0].t0 + 1) > int'(NSTAGE)) void'(q.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        rd_rs_en = 0; rd_rt_en = 0; ra_rs = 0; ra_rt = 0; tuse_rs = 0; tuse_rt = 0;
        wr_en = 0; wa = 0; tnew = 0; md_start = 0; md_is_div = 0; md_use = 0; flush = 0;
    endtask

    task automatic writer(input int r, input int t);
        idle();
        wr_en = 1; wa = 5'(r); tnew = 3'(t);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        busy_end = 0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.stall",   {2'b00, stall},   3'd0);
        check("reset.fwd_rs",  fwd_rs,           3'd0);
        check("reset.fwd_rt",  fwd_rt,           3'd0);
        check("reset.md_busy", {2'b00, md_busy}, 3'd0);
        reset = 1'b0;

        // lw $1 then dependent addu: one stall cycle
        writer(1, 2); settle("lw1"); tick();
        writer(2, 1); rd_rs_en = 1; rd_rt_en = 1; ra_rs = 1; ra_rt = 1; tuse_rs = 1; tuse_rt = 1;
        settle("addu_a"); check("lwuse.stall1", {2'b00, stall}, 3'd1); tick();
        settle("addu_b"); check("lwuse.stall2", {2'b00, stall}, 3'd0); tick();
        idle(); repeat (3) begin settle("drain"); tick(); end

        // addu $3 then sw $3: no stall, forward from stage 2 next cycle
        writer(3, 1); settle("addu3"); tick();
        idle(); rd_rt_en = 1; ra_rt = 3; tuse_rt = 2;
        settle("sw_a"); check("sw.stall", {2'b00, stall}, 3'd0); tick();
        settle("sw_b"); check("sw.fwd_rt", fwd_rt, 3'd2); tick();
        idle(); repeat (3) begin settle("drain"); tick(); end

        // mult then mflo: five stall cycles
        idle(); md_start = 1; settle("mult"); tick();
        writer(8, 1); md_use = 1;
        for (int i = 0; i < 6; i++) begin
            settle("mflo");
            check("mflo.stall", {2'b00, stall}, (i < 5) ? 3'd1 : 3'd0);
            tick();
        end
        idle(); repeat (3) begin settle("drain"); tick(); end

        // two writers of $4, youngest wins
        writer(4, 0); settle("w4a"); tick();
        writer(4, 0); settle("w4b"); tick();
        idle(); rd_rs_en = 1; ra_rs = 4; settle("rd4"); check("young.fwd_rs", fwd_rs, 3'd1); tick();
        idle(); repeat (3) begin settle("drain"); tick(); end

        // register 0 never hazards, disabled read never hazards
        writer(0, 3); settle("w0"); tick();
        idle(); rd_rs_en = 1; ra_rs = 0; settle("r0"); check("r0.stall", {2'b00, stall}, 3'd0);
        tick();
        writer(7, 3); settle("w7"); tick();
        idle(); ra_rs = 7; settle("r7off"); check("r7off.stall", {2'b00, stall}, 3'd0); tick();
        idle(); repeat (3) begin settle("drain"); tick(); end

        // flush kills lw $5 in stage 1
        writer(5, 2); settle("lw5"); tick();
        idle(); rd_rs_en = 1; ra_rs = 5; flush = 1;
        settle("flush"); check("flush.stall", {2'b00, stall}, 3'd0); tick();
        flush = 0; settle("postflush"); check("postflush.stall", {2'b00, stall}, 3'd0); tick();

        // reset during a div at count 7
        idle(); md_start = 1; md_is_div = 1; settle("div"); tick();
        idle(); repeat (3) begin settle("divrun"); tick(); end
        settle("div7"); check("div7.busy", {2'b00, md_busy}, 3'd1);
        reset = 1'b1;
        #1;
        check("rstmid.busy",  {2'b00, md_busy}, 3'd0);
        check("rstmid.stall", {2'b00, stall},   3'd0);
        q.delete();
        busy_end = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        md_use = 1; settle("afterrst"); check("afterrst.stall", {2'b00, stall}, 3'd0); tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rd_rs_en  = 1'($urandom_range(0, 1));
            rd_rt_en  = 1'($urandom_range(0, 1));
            ra_rs     = 5'($urandom_range(0, 7));
            ra_rt     = 5'($urandom_range(0, 7));
            tuse_rs   = 3'($urandom_range(0, 3));
            tuse_rt   = 3'($urandom_range(0, 3));
            wr_en     = 1'($urandom_range(0, 1));
            wa        = 5'($urandom_range(0, 7));
            tnew      = 3'($urandom_range(0, 3));
            md_start  = ($urandom_range(0, 7) == 0);
            md_is_div = 1'($urandom_range(0, 1));
            md_use    = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            settle("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
